// File: rtl/pkt_gen.sv
// Burst packet generator: LFSR-driven payload length and destination, ready/valid output.
// Optional checksum trailer word is compiled in with `define PKT_GEN_CHKSUM_EN.
module pkt_gen #(
  parameter int          PORT_NUB   = 8,
  parameter int          DATA_WIDTH = 16,
  parameter int          SRC_ID     = 0,
  parameter int          MAX_LEN    = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         WIDTH_SEL  = $clog2(PORT_NUB)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           pkt_num,
  input  logic                  fixed_dest_en,
  input  logic [WIDTH_SEL-1:0]  fixed_dest,
  input  logic                  ready,
  output logic [WIDTH_SEL-1:0]  rx_port,
  output logic [WIDTH_SEL-1:0]  tx_port,
  output logic [DATA_WIDTH-1:0] data_port,
  output logic                  valid,
  output logic                  sop,
  output logic                  eop,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] BASE   = DATA_WIDTH'(SRC_ID * 16);
  localparam logic [15:0]           TAPS   = 16'hB400;

  state_t               state;
  state_t               state_next;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_step;
  logic [8:0]           len;
  logic [8:0]           len_new;
  logic [8:0]           word_idx;
  logic [15:0]          pkt_cnt;
  logic [15:0]          pkt_total;
  logic [WIDTH_SEL-1:0] dest;
  logic [WIDTH_SEL-1:0] rand_dest;
  logic                 done_reg;
  logic [DATA_WIDTH-1:0] word_data;
  logic                 xfer;
  logic                 payload_last;
  logic                 last_word;
  logic                 last_pkt;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_step    = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign len_new      = 9'(int'(lfsr[15:8]) % MAX_LEN + 1);
  assign rand_dest    = WIDTH_SEL'(int'(lfsr[7:0]) % PORT_NUB);

  assign xfer         = (state == RUN) && ready;
  assign payload_last = (word_idx == len - 9'd1);
  assign last_pkt     = (pkt_cnt == pkt_total - 16'd1);
  assign word_data    = BASE + DATA_WIDTH'(word_idx);

`ifdef PKT_GEN_CHKSUM_EN
  logic                  in_trailer;
  logic [DATA_WIDTH-1:0] chk;

  // The trailer slot sits one index past the last payload word.
  assign in_trailer = (word_idx == len);
  assign last_word  = in_trailer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk <= '0;
    end else if (state == LOAD) begin
      chk <= '0;
    end else if (xfer && !in_trailer) begin
      chk <= chk ^ word_data;
    end
  end
`else
  assign last_word = payload_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (pkt_num == 16'd0) ? DONE : LOAD;
        end
      end
      LOAD: state_next = RUN;
      RUN: begin
        if (xfer && last_word) begin
          state_next = last_pkt ? DONE : GAP;
        end
      end
      GAP:     state_next = LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      len       <= '0;
      word_idx  <= '0;
      pkt_cnt   <= '0;
      pkt_total <= '0;
      dest      <= '0;
      done_reg  <= 1'b0;
    end else begin
      // done trails the DONE state by one cycle so it lands after the burst has closed.
      done_reg <= (state == DONE);
      if (state == IDLE && start) begin
        pkt_total <= pkt_num;
        pkt_cnt   <= '0;
      end
      if (state == LOAD) begin
        len      <= len_new;
        dest     <= fixed_dest_en ? fixed_dest : rand_dest;
        lfsr     <= lfsr_step;
        word_idx <= '0;
      end
      if (xfer) begin
        word_idx <= word_idx + 9'd1;
        if (last_word) begin
          pkt_cnt <= pkt_cnt + 16'd1;
        end
      end
    end
  end

  assign valid   = (state == RUN);
  assign sop     = valid && (word_idx == 9'd0);
  assign eop     = valid && last_word;
  assign busy    = (state != IDLE);
  assign done    = done_reg;
  assign rx_port = valid ? dest : '0;
  assign tx_port = valid ? WIDTH_SEL'(SRC_ID) : '0;

`ifdef PKT_GEN_CHKSUM_EN
  assign data_port = valid ? (in_trailer ? chk : word_data) : '0;
`else
  assign data_port = valid ? word_data : '0;
`endif

endmodule
